mem_stage: RTL and testbench

Memory-access stage of the rvcpu pipeline. It sits directly downstream of `exe_stage` and consumes that stage's result fields: ALU result/address, store data, destination register and memory-op controls. It performs aligned loads/stores over a request/grant/response data-memory port and produces a registered writeback packet for the register file. While an access is outstanding it stalls the upstream pipeline.

---
 rtl/mem_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the rvcpu pipeline.
// Issues aligned loads/stores on a req/gnt/rvalid data port, lane-shifts
// store data, extracts and extends load data, and produces a registered
// writeback packet. Stalls upstream while an access is outstanding.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (flag misaligned accesses
// instead of silently aligning the address down to the access size).
module mem_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_rd_mem,
  input  logic                  ex_wr_mem,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_rs2_value,
  input  logic                  ex_reg_write,
  input  logic [4:0]            ex_dest_reg_addr,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [7:0]            dmem_wstrb,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_dest_reg_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign_exc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] f_size_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      2'd3:    mask = 3'b111;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Byte enables for an access of the given size starting at lane off.
  function automatic logic [7:0] f_strb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      2'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Shift the addressed bytes down to lane 0, truncate to size, then extend.
  function automatic logic [DATA_WIDTH-1:0] f_load_extend(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [2:0]            off,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      2'd3:    res = sh;
      default: res = sh;
    endcase
    return res;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_done;
  logic                  w_memop;
  logic                  w_aligned;
  logic                  w_accept_mem;
  logic [2:0]            w_size_mask;
  logic [2:0]            w_off;

  logic                  r_is_load;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [2:0]            r_off;
  logic                  r_reg_write;
  logic [4:0]            r_rd;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic [7:0]            r_dmem_wstrb;
  logic                  r_wb_valid;
  logic                  r_wb_reg_write;
  logic [4:0]            r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_misalign;

  assign w_memop     = ex_rd_mem | ex_wr_mem;
  assign w_size_mask = f_size_mask(ex_mem_size);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_aligned = ~|(ex_alu_result[2:0] & w_size_mask);
  assign w_off     = ex_alu_result[2:0];
`else
  // Without the check, sub-size address bits are dropped before lane select.
  assign w_aligned = 1'b1;
  assign w_off     = ex_alu_result[2:0] & ~w_size_mask;
`endif

  assign w_accept_mem = (r_state == ST_IDLE) & ex_valid & w_memop & w_aligned;

  // Next-state, completion detect and upstream stall.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_mem) w_next_state = ST_REQ;
        else              w_next_state = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          w_done       = ~r_is_load;
          w_next_state = r_is_load ? ST_WAIT : ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_done       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
    mem_stall = w_accept_mem | ((r_state != ST_IDLE) & ~w_done);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Op latch, memory port registers and writeback packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_load      <= 1'b0;
      r_size         <= 2'd0;
      r_unsigned     <= 1'b0;
      r_off          <= 3'd0;
      r_reg_write    <= 1'b0;
      r_rd           <= 5'd0;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= {ADDR_WIDTH{1'b0}};
      r_dmem_wdata   <= {DATA_WIDTH{1'b0}};
      r_dmem_wstrb   <= 8'h00;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= {DATA_WIDTH{1'b0}};
      r_misalign     <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex_valid && !w_memop) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= ex_reg_write;
            r_wb_rd        <= ex_dest_reg_addr;
            r_wb_data      <= ex_alu_result;
          end else if (ex_valid && !w_aligned) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= ex_dest_reg_addr;
            r_wb_data      <= {DATA_WIDTH{1'b0}};
            r_misalign     <= 1'b1;
          end else if (w_accept_mem) begin
            // A load/store pair is treated as a load.
            r_is_load    <= ex_rd_mem;
            r_size       <= ex_mem_size;
            r_unsigned   <= ex_mem_unsigned;
            r_off        <= w_off;
            r_reg_write  <= ex_reg_write;
            r_rd         <= ex_dest_reg_addr;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= ~ex_rd_mem;
            r_dmem_addr  <= {ex_alu_result[ADDR_WIDTH-1:3], 3'b000};
            r_dmem_wdata <= ex_rs2_value << {w_off, 3'b000};
            r_dmem_wstrb <= ex_rd_mem ? 8'h00 : f_strb(ex_mem_size, w_off);
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (!r_is_load) begin
              r_wb_valid     <= 1'b1;
              r_wb_reg_write <= 1'b0;
              r_wb_rd        <= r_rd;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_reg_write;
            r_wb_rd        <= r_rd;
            r_wb_data      <= f_load_extend(dmem_rdata, r_off, r_size, r_unsigned);
          end
        end
        default: begin
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req         = r_dmem_req;
  assign dmem_we          = r_dmem_we;
  assign dmem_addr        = r_dmem_addr;
  assign dmem_wdata       = r_dmem_wdata;
  assign dmem_wstrb       = r_dmem_wstrb;
  assign wb_valid         = r_wb_valid;
  assign wb_reg_write     = r_wb_reg_write;
  assign wb_dest_reg_addr = r_wb_rd;
  assign wb_data          = r_wb_data;
  assign misalign_exc     = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a writeback/request
// reference model and a memory responder with programmable gnt/rvalid delays.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_rd_mem, ex_wr_mem, ex_mem_unsigned, ex_reg_write;
  logic [1:0]  ex_mem_size;
  logic [63:0] ex_alu_result, ex_rs2_value;
  logic [4:0]  ex_dest_reg_addr;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        wb_valid, wb_reg_write, misalign_exc;
  logic [4:0]  wb_dest_reg_addr;
  logic [63:0] wb_data;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd_mem(ex_rd_mem), .ex_wr_mem(ex_wr_mem),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_alu_result(ex_alu_result), .ex_rs2_value(ex_rs2_value),
    .ex_reg_write(ex_reg_write), .ex_dest_reg_addr(ex_dest_reg_addr),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_dest_reg_addr(wb_dest_reg_addr), .wb_data(wb_data),
    .misalign_exc(misalign_exc)
  );

  typedef struct {
    int          cyc;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          chk_data;
    logic        mis;
  } exp_wb_t;

  exp_wb_t     exp_q[$];
  int          n_vec = 0, n_fail = 0, cyc = 0, issue_cyc = 0, wb_count = 0, req_count = 0;
  int          gnt_delay = 0, rvalid_delay = 0, req_wait = 0, rv_cnt = -1;
  logic [63:0] resp_data = 64'd0;
  bit          exp_req_valid = 1'b0;
  logic        exp_req_we;
  logic [63:0] exp_req_addr, exp_req_wdata;
  logic [7:0]  exp_req_wstrb;
  logic [63:0] last_wb_data, last_req_addr, last_req_wdata;
  logic [7:0]  last_req_wstrb;
  logic [4:0]  last_wb_rd;
  logic        last_wb_rw, last_wb_mis;
  int          last_wb_cyc = 0;
  int          offs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bytes of the addressed element, moved to lane 0 and extended.
  function automatic logic [63:0] load_val(input logic [63:0] rdata, input int off,
                                           input int nb, input logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1]) for (int j = 8*nb; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] store_lanes(input logic [63:0] rs2, input int off);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8 - off; i++) w[8*(off+i) +: 8] = rs2[8*i +: 8];
    return w;
  endfunction

  function automatic logic [7:0] strb_of(input int off, input int nb);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < nb; i++) s[off+i] = 1'b1;
    return s;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory responder: gnt after gnt_delay REQ cycles, rvalid rvalid_delay cycles after the gnt cycle's successor.
  initial begin
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (rv_cnt == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = resp_data; rv_cnt = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (dmem_req === 1'b1) begin
        if (req_wait >= gnt_delay) begin
          dmem_gnt = 1'b1; req_wait = 0;
          if (dmem_we === 1'b0) rv_cnt = rvalid_delay;
        end else begin
          req_wait++;
        end
      end
    end
  end

  // Per-cycle compare of request and writeback outputs against the model.
  initial begin
    exp_wb_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (dmem_req === 1'b1) begin
          req_count++;
          last_req_addr = dmem_addr; last_req_wdata = dmem_wdata; last_req_wstrb = dmem_wstrb;
          if (!exp_req_valid) chk("unexpected_req", 64'(dmem_req), 64'd0);
          else begin
            chk("req_we", 64'(dmem_we), 64'(exp_req_we));
            chk("req_addr", dmem_addr, exp_req_addr);
            if (exp_req_we) begin
              chk("req_wdata", dmem_wdata, exp_req_wdata);
              chk("req_wstrb", 64'(dmem_wstrb), 64'(exp_req_wstrb));
            end
          end
        end
        if (wb_valid === 1'b1) begin
          wb_count++;
          last_wb_data = wb_data; last_wb_rd = wb_dest_reg_addr;
          last_wb_rw = wb_reg_write; last_wb_mis = misalign_exc; last_wb_cyc = cyc;
          if (exp_q.size() == 0) chk("unexpected_wb", 64'(wb_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            chk("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
            chk("wb_rd", 64'(wb_dest_reg_addr), 64'(e.rd));
            chk("wb_misalign", 64'(misalign_exc), 64'(e.mis));
            if (e.chk_data) chk("wb_data", wb_data, e.data);
          end
        end else begin
          chk("misalign_without_wb", 64'(misalign_exc), 64'd0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({dmem_req, dmem_we, dmem_wstrb, wb_valid, wb_reg_write,
                          wb_dest_reg_addr, misalign_exc, mem_stall}), 64'd0);
    chk({tag, "_addr"}, dmem_addr, 64'd0);
    chk({tag, "_wdata"}, dmem_wdata, 64'd0);
    chk({tag, "_wbdata"}, wb_data, 64'd0);
  endtask

  // Present one instruction at the start of a cycle and hold it while stalled.
  task automatic issue(input logic rdm, input logic wrm, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] rs2, input logic rw,
                       input logic [4:0] rd, input int gd, input int rvd, input logic [63:0] rdata);
    exp_wb_t         e;
    longint unsigned a, ea;
    int              nb, off, lat, stalls, guard;
    bit              memop, mis, ld;
    nb = 1 << sz;
    a = addr;
    memop = rdm | wrm;
    ld = rdm;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = memop && ((a % nb) != 0);
    ea = a;
`else
    mis = 1'b0;
    ea = a - (a % nb);
`endif
    off = int'(ea % 8);
    if (!memop || mis) lat = 1;
    else if (!ld)      lat = 2 + gd;
    else               lat = 3 + gd + rvd;
    e.cyc = cyc + lat;
    e.rw = !memop ? rw : ((ld && !mis) ? rw : 1'b0);
    e.rd = rd;
    e.mis = mis;
    e.chk_data = !memop || (ld && !mis);
    e.data = !memop ? addr : load_val(rdata, off, nb, uns);
    exp_q.push_back(e);
    if (memop && !mis) begin
      exp_req_addr = 64'(ea - (ea % 8));
      exp_req_we = !ld;
      exp_req_wdata = store_lanes(rs2, off);
      exp_req_wstrb = strb_of(off, nb);
      exp_req_valid = 1'b1;
    end
    gnt_delay = gd; rvalid_delay = rvd; resp_data = rdata;
    ex_rd_mem = rdm; ex_wr_mem = wrm; ex_mem_size = sz; ex_mem_unsigned = uns;
    ex_alu_result = addr; ex_rs2_value = rs2; ex_reg_write = rw; ex_dest_reg_addr = rd;
    ex_valid = 1'b1;
    issue_cyc = cyc;
    stalls = 0; guard = 0;
    @(negedge clk);
    while (mem_stall === 1'b1 && guard < 64) begin
      stalls++; guard++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(stalls), 64'(lat - 1));
    @(posedge clk); #1;
    ex_valid = 1'b0;
    exp_req_valid = 1'b0;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    int saved;
    offs = '{5, 6, 4, 0};
    rst = 1'b1; ex_valid = 1'b0; ex_rd_mem = 1'b0; ex_wr_mem = 1'b0; ex_mem_size = 2'd0;
    ex_mem_unsigned = 1'b0; ex_alu_result = 64'd0; ex_rs2_value = 64'd0;
    ex_reg_write = 1'b0; ex_dest_reg_addr = 5'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    next_cycle();
    rst = 1'b0;
    settle();
    check_zero("post_reset");
    next_cycle();

    // ALU op
    issue(1'b0, 1'b0, 2'd3, 1'b0, 64'h1234, 64'd0, 1'b1, 5'd5, 0, 0, 64'd0);
    settle();
    chk("alu_data", last_wb_data, 64'h1234);
    chk("alu_rd", 64'(last_wb_rd), 64'd5);
    chk("alu_latency", 64'(last_wb_cyc - issue_cyc), 64'd1);
    next_cycle();

    // Store half, gnt two cycles late
    issue(1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 64'hABCD, 1'b1, 5'd9, 2, 0, 64'd0);
    settle();
    chk("sh_addr", last_req_addr, 64'h1000);
    chk("sh_wstrb", 64'(last_req_wstrb), 64'hC0);
    chk("sh_wdata", last_req_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_reg_write", 64'(last_wb_rw), 64'd0);
    chk("sh_latency", 64'(last_wb_cyc - issue_cyc), 64'd4);
    next_cycle();

    // Byte loads, signed then unsigned
    issue(1'b1, 1'b0, 2'd0, 1'b0, 64'h2003, 64'd0, 1'b1, 5'd3, 0, 0, 64'h1122_3344_8066_7788);
    settle();
    chk("lb_data", last_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_latency", 64'(last_wb_cyc - issue_cyc), 64'd3);
    next_cycle();
    issue(1'b1, 1'b0, 2'd0, 1'b1, 64'h2003, 64'd0, 1'b1, 5'd3, 0, 0, 64'h1122_3344_8066_7788);
    settle();
    chk("lbu_data", last_wb_data, 64'h80);
    chk("lbu_latency", 64'(last_wb_cyc - issue_cyc), 64'd3);
    next_cycle();

    // Word load at a misaligned address
    saved = req_count;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0, 1'b1, 5'd4, 0, 0, 64'h1122_3344_8566_7788);
    settle();
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_exc", 64'(last_wb_mis), 64'd1);
    chk("mis_reg_write", 64'(last_wb_rw), 64'd0);
    chk("mis_no_req", 64'(req_count - saved), 64'd0);
    chk("mis_latency", 64'(last_wb_cyc - issue_cyc), 64'd1);
`else
    chk("lw_forced_addr", last_req_addr, 64'h3000);
    chk("lw_forced_data", last_wb_data, 64'hFFFF_FFFF_8566_7788);
    chk("lw_no_exc", 64'(last_wb_mis), 64'd0);
`endif
    next_cycle();

    // Back-to-back load, ALU, store with zero-wait memory
    saved = wb_count;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h4008, 64'd0, 1'b1, 5'd10, 0, 0, 64'hDEAD_BEEF_0123_4567);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h55AA, 64'd0, 1'b1, 5'd11, 0, 0, 64'd0);
    issue(1'b0, 1'b1, 2'd0, 1'b0, 64'h4011, 64'h7F, 1'b1, 5'd12, 0, 0, 64'd0);
    settle();
    chk("b2b_wb_count", 64'(wb_count - saved), 64'd3);
    chk("b2b_last_rd", 64'(last_wb_rd), 64'd12);
    next_cycle();

    // Sizes and offsets sweep; wr_mem also raised on half the loads
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        issue(1'b1, 1'(u), 2'(s), 1'(u), 64'h5000 + 64'(offs[s]) + 64'(16 * s), 64'd0, 1'b1,
              5'(16 + s), s % 2, u, {$urandom(), $urandom()});
      end
      issue(1'b0, 1'b1, 2'(s), 1'b0, 64'h6008 + 64'(offs[s]), {$urandom(), $urandom()}, 1'b1,
            5'(20 + s), 1 - (s % 2), 0, 64'd0);
    end
    issue(1'b0, 1'b1, 2'd3, 1'b0, 64'h7005, 64'h0102_0304_0506_0708, 1'b1, 5'd25, 1, 0, 64'd0);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 64'hCAFE, 64'd0, 1'b0, 5'd26, 0, 0, 64'd0);
    repeat (3) next_cycle();

    // Reset while a load waits for its data
    ex_rd_mem = 1'b1; ex_wr_mem = 1'b0; ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0;
    ex_alu_result = 64'h2003; ex_reg_write = 1'b1; ex_dest_reg_addr = 5'd7; ex_valid = 1'b1;
    gnt_delay = 0; rvalid_delay = 3; resp_data = 64'h0000_0000_8000_0000;
    exp_req_addr = 64'h2000; exp_req_we = 1'b0; exp_req_valid = 1'b1;
    next_cycle();
    next_cycle();
    chk("wait_stall", 64'(mem_stall), 64'd1);
    saved = wb_count;
    rst = 1'b1; ex_valid = 1'b0; exp_req_valid = 1'b0;
    settle();
    chk("rst_stall", 64'(mem_stall), 64'd0);
    next_cycle();
    rst = 1'b0;
    repeat (5) next_cycle();
    settle();
    chk("rst_no_wb", 64'(wb_count - saved), 64'd0);
    check_zero("rst_mid_wait");
    next_cycle();
    issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h77, 64'd0, 1'b1, 5'd1, 0, 0, 64'd0);
    settle();
    chk("post_rst_alu", last_wb_data, 64'h77);
    next_cycle();

    chk("wb_pending", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
